// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encodings, default timing constants and
// a cycle-count helper used by both the host transmitter and the receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_REQ      = 3'd2,
        ST_BITS     = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAIT_REL = 3'd5
    } ps2_state_e;

    localparam logic [15:0] DEF_INHIBIT_US = 16'd120;
    localparam logic [15:0] DEF_REQ_US     = 16'd5;
    localparam logic [15:0] DEF_TIMEOUT_MS = 16'd15;

    // Index of the stop-bit edge; the ACK edge follows it.
    localparam logic [3:0]  IDX_STOP       = 4'd9;

    // Widen before multiplying so long intervals cannot overflow 16 bits.
    function automatic logic [31:0] us_to_cycles(input logic [15:0] mhz,
                                                 input logic [31:0] us);
        return {16'd0, mhz} * us;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line plus falling-edge detect.
// Flops reset to 1, matching an idle (released, pulled-up) line.
module ps2_sync_edge (
    input  logic clock,
    input  logic nReset,
    input  logic din,
    output logic q,
    output logic fall
);

    logic [2:0] sr;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            sr <= 3'b111;
        end else begin
            sr <= {sr[1:0], din};
        end
    end

    assign q    = sr[1];
    assign fall = sr[2] & ~sr[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked
// data/parity/stop, ACK check. Macro PS2_TX_TIMEOUT_EN adds a watchdog.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | lines released, waiting for tx_start
// ST_INHIBIT  | clock held low for the inhibit interval
// ST_REQ      | clock and data low (start bit) for the request interval
// ST_BITS     | clock released; device edges shift data, parity, stop
// ST_ACK      | next device falling edge samples the ACK bit
// ST_WAIT_REL | wait for both lines high, then report done or ack_err
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter logic [15:0] CLK_MHZ    = 16'd50,
    parameter logic [15:0] INHIBIT_US = DEF_INHIBIT_US,
    parameter logic [15:0] REQ_US     = DEF_REQ_US,
    parameter logic [15:0] TIMEOUT_MS = DEF_TIMEOUT_MS
) (
    input  logic       clock,
    input  logic       nReset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam logic [31:0] INHIBIT_CYC = us_to_cycles(CLK_MHZ, {16'd0, INHIBIT_US});
    localparam logic [31:0] REQ_CYC     = us_to_cycles(CLK_MHZ, {16'd0, REQ_US});

    ps2_state_e  state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        parity_q, parity_d;
    logic        dat_oe_q, dat_oe_d;
    logic        ack_bad_q, ack_bad_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;

    logic clk_sync, clk_fall;
    logic dat_sync, dat_fall;

    ps2_sync_edge u_sync_clk (
        .clock  (clock),
        .nReset (nReset),
        .din    (ps2_clk_i),
        .q      (clk_sync),
        .fall   (clk_fall)
    );

    ps2_sync_edge u_sync_dat (
        .clock  (clock),
        .nReset (nReset),
        .din    (ps2_dat_i),
        .q      (dat_sync),
        .fall   (dat_fall)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [31:0] WD_CYC =
        us_to_cycles(CLK_MHZ, {16'd0, TIMEOUT_MS} * 32'd1000);

    logic [31:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;
`endif

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            ack_bad_q <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            dat_oe_q  <= dat_oe_d;
            ack_bad_q <= ack_bad_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        data_d    = data_q;
        parity_d  = parity_q;
        dat_oe_d  = dat_oe_q;
        ack_bad_d = ack_bad_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                idx_d    = '0;
                dat_oe_d = 1'b0;
                if (tx_start) begin
                    data_d   = tx_data;
                    parity_d = ~^tx_data;
                    timer_d  = INHIBIT_CYC - 32'd1;
                    state_d  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (timer_q == '0) begin
                    timer_d = REQ_CYC - 32'd1;
                    state_d = ST_REQ;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_REQ: begin
                if (timer_q == '0) begin
                    // Start bit stays driven until the device's first edge.
                    dat_oe_d = 1'b1;
                    idx_d    = '0;
                    state_d  = ST_BITS;
`ifdef PS2_TX_TIMEOUT_EN
                    wd_d     = WD_CYC - 32'd1;
`endif
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_BITS: begin
                if (clk_fall) begin
                    if (idx_q < 4'd8) begin
                        dat_oe_d = ~data_q[idx_q[2:0]];
                    end else if (idx_q < IDX_STOP) begin
                        dat_oe_d = ~parity_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = ST_ACK;
                    end
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    ack_bad_d = dat_sync;
                    state_d   = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (clk_sync && dat_sync) begin
                    done_d    = ~ack_bad_q;
                    ack_err_d = ack_bad_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog wins over any same-cycle completion so pulses stay exclusive.
        if (state_q == ST_BITS || state_q == ST_ACK || state_q == ST_WAIT_REL) begin
            if (wd_q == '0) begin
                state_d   = ST_IDLE;
                dat_oe_d  = 1'b0;
                idx_d     = '0;
                done_d    = 1'b0;
                ack_err_d = 1'b0;
                timeout_d = 1'b1;
            end else begin
                wd_d = wd_q - 32'd1;
            end
        end
`endif
    end

    assign ps2_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
    assign ps2_dat_oe = (state_q == ST_REQ) || dat_oe_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign ack_err    = ack_err_q;

`ifdef PS2_TX_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 device model.
module tb_ps2_host_tx;

    logic       clock   = 1'b0;
    logic       nReset  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_i, ps2_dat_i;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_ackerr = 0;
    int n_to     = 0;
    int n_bad    = 0;

    assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

    always #5 clock = ~clock;

    ps2_host_tx dut (
        .clock      (clock),
        .nReset     (nReset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout    (timeout)
    );

    always @(negedge clock) begin
        if (done)    n_done   = n_done + 1;
        if (ack_err) n_ackerr = n_ackerr + 1;
        if (timeout) n_to     = n_to + 1;
        if ((done && busy) || (int'(done) + int'(ack_err) + int'(timeout) > 1))
            n_bad = n_bad + 1;
    end

    task automatic start_tx(input logic [7:0] b);
        @(negedge clock);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
    endtask

    // bits[0] = start, bits[8:1] = data LSB first, bits[9] = parity, bits[10] = stop
    task automatic run_device(input logic ack_low, input int inject_at,
                              input int stop_at, output logic [10:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (ps2_clk_oe && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (ps2_clk_oe) begin
            n_checks++;
            n_fail++;
            $display("FAIL release_wait: clk_oe still %0b after %0d cycles", ps2_clk_oe, n);
        end
        bits[0] = ps2_dat_i;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_dat = ~ack_low;
            repeat (5) @(negedge clock);
            dev_clk = 1'b0;
            repeat (20) @(negedge clock);
            if (k <= 10) bits[k] = ps2_dat_i;
            dev_clk = 1'b1;
            if (k == 11) dev_dat = 1'b1;
            repeat (15) @(negedge clock);
            if (k == inject_at) begin
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clock);
                tx_start = 1'b0;
            end
            if (k == stop_at) return;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout});
        end
        nReset = 1'b1;
        repeat (5) @(negedge clock);
        n_checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
    endtask

    task automatic test_send_ed();
        logic [10:0] bits;
        int d0, e0;
        d0 = n_done;
        e0 = n_ackerr;
        start_tx(8'hED);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ed_busy: got %b expected 1", busy);
        end
        run_device(1'b1, -1, -1, bits);
        n_checks++;
        if (bits !== {1'b1, 1'b1, 8'hED, 1'b0}) begin
            n_fail++;
            $display("FAIL ed_bits: got %b expected %b", bits, {1'b1, 1'b1, 8'hED, 1'b0});
        end
        wait_idle();
        n_checks++;
        if (n_done - d0 !== 1 || n_ackerr - e0 !== 0) begin
            n_fail++;
            $display("FAIL ed_pulses: done %0d ack_err %0d expected 1 0", n_done - d0, n_ackerr - e0);
        end
        n_checks++;
        if ({busy, ps2_clk_oe, ps2_dat_oe} !== 3'b0) begin
            n_fail++;
            $display("FAIL ed_idle: got %b expected 000", {busy, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_zero_timing();
        logic [10:0] bits;
        int n_inh, n_req, d0;
        d0 = n_done;
        start_tx(8'h00);
        n_inh = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n_inh < 20000) begin
            n_inh++;
            @(negedge clock);
        end
        n_req = 0;
        while (ps2_clk_oe && ps2_dat_oe && n_req < 20000) begin
            n_req++;
            @(negedge clock);
        end
        n_checks++;
        if (n_inh !== 6000) begin
            n_fail++;
            $display("FAIL inhibit_len: got %0d expected 6000", n_inh);
        end
        n_checks++;
        if (n_req !== 250) begin
            n_fail++;
            $display("FAIL req_len: got %0d expected 250", n_req);
        end
        run_device(1'b1, -1, -1, bits);
        n_checks++;
        if (bits !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_bits: got %b expected %b", bits, {1'b1, 1'b1, 8'h00, 1'b0});
        end
        wait_idle();
        n_checks++;
        if (n_done - d0 !== 1) begin
            n_fail++;
            $display("FAIL zero_done: got %0d expected 1", n_done - d0);
        end
    endtask

    task automatic test_ack_err();
        logic [10:0] bits;
        int d0, e0;
        d0 = n_done;
        e0 = n_ackerr;
        start_tx(8'hFF);
        run_device(1'b0, -1, -1, bits);
        n_checks++;
        if (bits !== {1'b1, 1'b1, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL ff_bits: got %b expected %b", bits, {1'b1, 1'b1, 8'hFF, 1'b0});
        end
        wait_idle();
        n_checks++;
        if (n_ackerr - e0 !== 1 || n_done - d0 !== 0) begin
            n_fail++;
            $display("FAIL ff_pulses: ack_err %0d done %0d expected 1 0", n_ackerr - e0, n_done - d0);
        end
    endtask

    task automatic test_back_to_back_start();
        logic [10:0] bits;
        int d0;
        d0 = n_done;
        start_tx(8'hF4);
        run_device(1'b1, 3, -1, bits);
        n_checks++;
        if (bits !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin
            n_fail++;
            $display("FAIL f4_bits: got %b expected %b", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
        end
        wait_idle();
        n_checks++;
        if (n_done - d0 !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL f4_done: done %0d busy %b expected 1 0", n_done - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] bits;
        int d0, e0, t0;
        d0 = n_done;
        e0 = n_ackerr;
        t0 = n_to;
        start_tx(8'h00);
        run_device(1'b1, -1, 5, bits);
        n_checks++;
        if (ps2_dat_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_dat_driven: got %b expected 1", ps2_dat_oe);
        end
        #2;
        nReset = 1'b0;
        #1;
        n_checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b0) begin
            n_fail++;
            $display("FAIL mid_reset_release: got %b expected 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
        repeat (5) @(negedge clock);
        nReset = 1'b1;
        repeat (50) @(negedge clock);
        n_checks++;
        if (n_done - d0 !== 0 || n_ackerr - e0 !== 0 || n_to - t0 !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_pulses: done %0d ack_err %0d timeout %0d expected 0 0 0",
                     n_done - d0, n_ackerr - e0, n_to - t0);
        end
    endtask

    task automatic test_no_clock();
        int n, t0;
        t0 = n_to;
        start_tx(8'h12);
        n = 0;
        while (ps2_clk_oe && n < 20000) begin
            @(negedge clock);
            n++;
        end
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        while (!timeout && n < 760000) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (n !== 750000) begin
            n_fail++;
            $display("FAIL timeout_at: got %0d expected 750000", n);
        end
        n_checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b0) begin
            n_fail++;
            $display("FAIL timeout_release: got %b expected 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
`else
        repeat (1000) @(negedge clock);
        n_checks++;
        if (busy !== 1'b1 || n_to - t0 !== 0) begin
            n_fail++;
            $display("FAIL no_watchdog: busy %b timeouts %0d expected 1 0", busy, n_to - t0);
        end
        nReset = 1'b0;
        repeat (3) @(negedge clock);
        nReset = 1'b1;
        repeat (3) @(negedge clock);
`endif
    endtask

    task automatic test_pulse_rules();
        n_checks++;
        if (n_bad !== 0) begin
            n_fail++;
            $display("FAIL pulse_rules: got %0d violations expected 0", n_bad);
        end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_zero_timing();
        test_ack_err();
        test_back_to_back_start();
        test_reset_mid();
        test_no_clock();
        test_pulse_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
